// File: rtl/mmio_if.sv
// mmio_if: data-memory bus, retire strobe and UART ready/valid ports of the MMIO block.
interface mmio_if;
    logic        mem_en;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        inst_retire;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    modport slave (
        input  mem_en, addr, we, din, inst_retire, uart_rx_data, uart_rx_valid, uart_tx_ready,
        output dout, uart_rx_ready, uart_tx_data, uart_tx_valid
    );
    modport master (
        output mem_en, addr, we, din, inst_retire, uart_rx_data, uart_rx_valid, uart_tx_ready,
        input  dout, uart_rx_ready, uart_tx_data, uart_tx_valid
    );
endinterface

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: memory-mapped UART rx/tx registers plus free-running cycle and retired-instruction counters.
module mmio_ctrl #(
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
    input logic    clk,
    input logic    rst,
    mmio_if.slave  bus
);
    logic        hit, ld, st, rx_ld, tx_go, clr, tx_free, tx_pending;
    logic [7:0]  off, tx_buf;
    logic [31:0] cyc_cnt, ins_cnt, rdata;
    assign hit     = bus.mem_en && bus.addr[31:28] == MMIO_BASE[31:28];
    assign off     = bus.addr[7:0];
    assign ld      = hit && bus.we == 4'b0000;
    assign st      = hit && bus.we != 4'b0000;
    assign rx_ld   = ld && off == 8'h04;
    assign tx_free = bus.uart_tx_ready && !tx_pending;
    // A store arriving while a byte is still pending is dropped, even if that byte hands off this cycle.
    assign tx_go   = st && off == 8'h08 && bus.we[0] && !tx_pending;
    assign clr     = st && off == 8'h18;
    assign bus.uart_rx_ready = rx_ld && !rst;
    assign bus.uart_tx_valid = tx_pending && !rst;
    assign bus.uart_tx_data  = tx_buf;
    always_comb begin
        rdata = !ld            ? 32'h0 :
                off == 8'h00   ? {30'b0, bus.uart_rx_valid, tx_free} :
                off == 8'h04   ? {24'b0, bus.uart_rx_data} :
                off == 8'h10   ? cyc_cnt :
                off == 8'h14   ? ins_cnt : 32'h0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dout   <= 32'h0;
            cyc_cnt    <= 32'h0;
            ins_cnt    <= 32'h0;
            tx_pending <= 1'b0;
            tx_buf     <= 8'h0;
        end else begin
            bus.dout <= rdata;
            cyc_cnt  <= clr ? 32'h0 : cyc_cnt + 32'd1;
            ins_cnt  <= clr ? 32'h0 : ins_cnt + {31'b0, bus.inst_retire};
            if (tx_go) begin
                tx_buf     <= bus.din[7:0];
                tx_pending <= 1'b1;
            end else if (tx_pending && bus.uart_tx_ready) begin
                tx_pending <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mmio_ctrl.sv
// tb_mmio_ctrl: directed vectors with hand-computed expectations for mmio_ctrl.
module tb_mmio_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    mmio_if bus();
    mmio_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic acc(input logic en, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        bus.mem_en = en;
        bus.addr   = a;
        bus.we     = w;
        bus.din    = d;
    endtask
    task automatic idle;
        acc(1'b0, 32'h0, 4'h0, 32'h0);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        idle();
        bus.inst_retire   = 1'b0;
        bus.uart_rx_data  = 8'h00;
        bus.uart_rx_valid = 1'b1;
        bus.uart_tx_ready = 1'b0;
        // Reset: rx_ready must stay low even with an rx load presented
        acc(1'b1, 32'h8000_0004, 4'h0, 32'h0);
        #1;
        check("rst_rx_ready", {31'b0, bus.uart_rx_ready}, 32'h0);
        repeat (3) tick();
        check("rst_dout", bus.dout, 32'h0);
        check("rst_tx_valid", {31'b0, bus.uart_tx_valid}, 32'h0);
        check("rst_rx_ready2", {31'b0, bus.uart_rx_ready}, 32'h0);
        idle();
        bus.uart_rx_valid = 1'b0;
        rst = 1'b0;
        repeat (10) tick();
        acc(1'b1, 32'h8000_0010, 4'h0, 32'h0);
        tick();
        check("cyc_after_10", bus.dout, 32'd10);
        acc(1'b1, 32'h8000_0014, 4'h0, 32'h0);
        tick();
        check("ins_zero", bus.dout, 32'd0);
        idle();
        bus.inst_retire = 1'b1;
        repeat (5) tick();
        bus.inst_retire = 1'b0;
        acc(1'b1, 32'h8000_0014, 4'h0, 32'h0);
        tick();
        check("ins_five", bus.dout, 32'd5);
        // Read-only/write-only/no-hit behaviour
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        acc(1'b1, 32'h8000_0010, 4'hF, 32'hFFFF_0000);
        tick();
        acc(1'b1, 32'h8000_0010, 4'h0, 32'h0);
        tick();
        check("ro_store_ignored", bus.dout, 32'd1);
        acc(1'b0, 32'h8000_0010, 4'h0, 32'h0);
        tick();
        check("no_en_dout", bus.dout, 32'h0);
        acc(1'b1, 32'h8000_0010, 4'h0, 32'h0);
        tick();
        check("cyc_again", bus.dout, 32'd3);
        acc(1'b1, 32'h9000_0010, 4'h0, 32'h0);
        tick();
        check("no_hit_dout", bus.dout, 32'h0);
        acc(1'b1, 32'h8000_0008, 4'h0, 32'h0);
        tick();
        check("wo_tx_load", bus.dout, 32'h0);
        acc(1'b1, 32'h8000_0010, 4'h0, 32'h0);
        tick();
        acc(1'b1, 32'h8000_0018, 4'h0, 32'h0);
        tick();
        check("wo_clr_load", bus.dout, 32'h0);
        bus.uart_tx_ready = 1'b1;
        acc(1'b0, 32'h8000_0008, 4'h1, 32'h55);
        tick();
        check("no_en_tx", {31'b0, bus.uart_tx_valid}, 32'h0);
        // Transmit with immediate handshake
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        acc(1'b1, 32'h8000_0008, 4'h1, 32'h41);
        tick();
        check("tx_valid", {31'b0, bus.uart_tx_valid}, 32'h1);
        check("tx_data", {24'b0, bus.uart_tx_data}, 32'h41);
        acc(1'b1, 32'h8000_0000, 4'h0, 32'h0);
        tick();
        check("status_busy", bus.dout, 32'h0);
        check("tx_valid_done", {31'b0, bus.uart_tx_valid}, 32'h0);
        tick();
        check("status_free", bus.dout, 32'h1);
        // Store while pending is dropped, including on the handshake cycle
        bus.uart_tx_ready = 1'b0;
        acc(1'b1, 32'h8000_0008, 4'h1, 32'h41);
        tick();
        acc(1'b1, 32'h8000_0008, 4'h1, 32'h42);
        tick();
        idle();
        tick();
        check("hold_valid", {31'b0, bus.uart_tx_valid}, 32'h1);
        check("hold_data", {24'b0, bus.uart_tx_data}, 32'h41);
        bus.uart_tx_ready = 1'b1;
        acc(1'b1, 32'h8000_0008, 4'h1, 32'h43);
        tick();
        check("hs_store_drop_valid", {31'b0, bus.uart_tx_valid}, 32'h0);
        check("hs_store_drop_data", {24'b0, bus.uart_tx_data}, 32'h41);
        acc(1'b1, 32'h8000_0008, 4'h2, 32'h4400);
        tick();
        check("tx_we0_low", {31'b0, bus.uart_tx_valid}, 32'h0);
        // Receive path
        bus.uart_tx_ready = 1'b0;
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = 8'h5A;
        acc(1'b1, 32'h8000_0000, 4'h0, 32'h0);
        #1;
        check("status_rx_ready", {31'b0, bus.uart_rx_ready}, 32'h0);
        tick();
        check("status_rx", bus.dout, 32'h2);
        acc(1'b1, 32'h8000_0004, 4'h0, 32'h0);
        #1;
        check("rx_ready_pulse", {31'b0, bus.uart_rx_ready}, 32'h1);
        tick();
        check("rx_data", bus.dout, 32'h5A);
        idle();
        #1;
        check("rx_ready_low", {31'b0, bus.uart_rx_ready}, 32'h0);
        bus.uart_rx_valid = 1'b0;
        acc(1'b1, 32'h8000_0004, 4'h0, 32'h0);
        tick();
        check("rx_data_novalid", bus.dout, 32'h5A);
        idle();
        // Cycle counter wrap
        force dut.cyc_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.cyc_cnt;
        repeat (3) tick();
        acc(1'b1, 32'h8000_0010, 4'h0, 32'h0);
        tick();
        check("cyc_wrap", bus.dout, 32'd1);
        // Counter clear wins over retire increment
        bus.inst_retire = 1'b1;
        idle();
        repeat (4) tick();
        acc(1'b1, 32'h8000_0018, 4'h4, 32'h0);
        tick();
        bus.inst_retire = 1'b0;
        acc(1'b1, 32'h8000_0010, 4'h0, 32'h0);
        tick();
        check("clr_cyc", bus.dout, 32'd0);
        acc(1'b1, 32'h8000_0014, 4'h0, 32'h0);
        tick();
        check("clr_ins", bus.dout, 32'd0);
        acc(1'b1, 32'h8000_0010, 4'h0, 32'h0);
        tick();
        check("clr_cyc_resume", bus.dout, 32'd2);
        // Reset abandons an in-flight byte
        bus.uart_tx_ready = 1'b0;
        acc(1'b1, 32'h8000_0008, 4'h1, 32'h41);
        tick();
        idle();
        #1;
        check("pend_before_rst", {31'b0, bus.uart_tx_valid}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_masks_valid", {31'b0, bus.uart_tx_valid}, 32'h0);
        tick();
        rst = 1'b0;
        bus.uart_tx_ready = 1'b1;
        #1;
        check("rst_drop_tx", {31'b0, bus.uart_tx_valid}, 32'h0);
        tick();
        acc(1'b1, 32'h8000_0010, 4'h0, 32'h0);
        tick();
        check("rst_cyc_resume", bus.dout, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_ctrl.md
MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 SHALL have parameter MMIO_BASE, default 32'h8000_0000, base byte address of the MMIO region.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have mem_en  input  1  data-memory access enable from EX/MEM boundary, same cycle as addr.
REQ-005 SHALL have addr  input  32  byte address of access (ALU result).
REQ-006 SHALL have we  input  4  byte write enables; 4'b0000 = load.
REQ-007 SHALL have din  input  32  store data, already lane-aligned.
REQ-008 SHALL have dout  output  32  load data, valid cycle after access, for the writeback load mux.
REQ-009 SHALL have inst_retire  input  1  one non-bubble instruction completes this cycle.
REQ-010 SHALL have uart_rx_data  input  8, uart_rx_valid  input  1, uart_rx_ready  output  1  UART receive ready/valid port.
REQ-011 SHALL have uart_tx_data  output  8, uart_tx_valid  output  1, uart_tx_ready  input  1  UART transmit ready/valid port.

Function
REQ-012 SHALL decode hit = mem_en AND addr[31:28] == MMIO_BASE[31:28]; offset = addr[7:0]; no hit = no side effect, dout 0.
REQ-013 SHALL map: 0x00 status RO {30'b0, rx_valid, tx_free}; 0x04 rx data RO {24'b0, uart_rx_data}; 0x08 tx data WO; 0x10 cycle counter RO; 0x14 instruction counter RO; 0x18 counter reset WO.
REQ-014 SHALL register dout: load hit at cycle N -> dout at N+1 holds value sampled at N; dout 0 for write-only/unmapped offsets or non-hit loads.
REQ-015 SHALL define tx_free = uart_tx_ready AND NOT tx_pending.
REQ-016 SHALL drive uart_rx_ready high, combinationally, only in the cycle of a load hit at 0x04; byte consumed iff uart_rx_valid also high that cycle; rx load with rx_valid low returns {24'b0, uart_rx_data} without consuming.
REQ-017 SHALL, on store hit at 0x08 with we[0]=1 and tx_pending=0, latch din[7:0] into tx buffer and set tx_pending next cycle.
REQ-018 SHALL drive uart_tx_valid = tx_pending and uart_tx_data = tx buffer; clear tx_pending on the cycle after uart_tx_valid AND uart_tx_ready.
REQ-019 SHALL drop a tx store while tx_pending=1 (buffer unchanged); if handshake completes that same cycle, store still dropped.
REQ-020 SHALL increment the 32-bit cycle counter every non-reset cycle, wrapping 0xFFFF_FFFF -> 0.
REQ-021 SHALL increment the 32-bit instruction counter in each non-reset cycle with inst_retire=1, wrapping.
REQ-022 SHALL, on store hit at 0x18 with any we bit set, set both counters to 0 next cycle; clear takes priority over increment.
REQ-023 SHALL ignore stores to read-only offsets; loads and stores SHALL never stall (fixed one-cycle latency).

Reset
REQ-024 SHALL, with rst high at a clock edge, set dout=0, both counters=0, tx_pending=0, tx buffer=0; uart_tx_valid=0 and uart_rx_ready=0 while rst high.
REQ-025 SHALL abandon an in-flight tx byte on reset (not retransmitted); counters resume from 0 on first cycle after rst falls.

Verification
REQ-026 Reset 3 cycles, release, wait 10 cycles, load 0x8000_0010 -> dout = 10 next cycle; load 0x8000_0014 with inst_retire held 0 -> 0.
REQ-027 uart_tx_ready=1, store 0x41 to 0x8000_0008 -> next cycle uart_tx_valid=1, uart_tx_data=0x41, status bit0=0; after handshake, valid=0, status bit0=1.
REQ-028 uart_tx_ready=0, stores 0x41 then 0x42 to 0x08 -> tx_data stays 0x41 until handshake; 0x42 never emitted.
REQ-029 uart_rx_valid=1, rx_data=0x5A: load 0x8000_0000 -> dout=0x2 (tx_ready=0) with rx_ready low; load 0x8000_0004 -> rx_ready pulses one cycle, dout=0x5A.
REQ-030 Cycle counter at 0xFFFF_FFFE, run 3 cycles -> reads 0x0000_0001; store to 0x18 while inst_retire=1 -> both counters 0 next cycle, then cycle counter 1.
REQ-031 Store to 0x8000_0010, load 0x8000_0008, access with mem_en=0 at 0x8000_0008 -> counters unchanged, dout=0, no tx.
